hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline hazard and stall controller for the 5-stage ARM-style core, sequencing the D/E, E/M (FLOPMEM) and M/W pipeline registers.
- Generates operand-forwarding selects for the execute stage.
- Resolves load-use stalls and flushes wrong-path instructions when PCSrcM is taken.
- Freezes the pipeline via a wait-state FSM while the data memory is not ready, with timeout error and stall counter.

Parameters:
REG_W, 4, register-index width
MEM_TIMEOUT, 16, stalled cycles allowed per memory access before forced release (>=1)
CNT_W, 16, stall performance counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
RA1D, RA2D  in  REG_W  source registers in Decode
RA1E, RA2E  in  REG_W  source registers in Execute
WA3E, WA3M, WA3W  in  REG_W  destination registers in E, M, W
RegWriteE, RegWriteM, RegWriteW  in  1  register-write flags per stage
MemtoRegE  in  1  load in Execute
MemtoRegM, MemWriteM  in  1  load/store in Memory stage
PCSrcM  in  1  taken branch / PC write resolved in Memory stage
mem_ready  in  1  data memory completes access this cycle
ForwardAE, ForwardBE  out  2  00 regfile, 01 from W, 10 from M
StallF, StallD, StallE  out  1  hold PC, F/D, D/E registers
EnM  out  1  enable for E/M register (FLOPMEM); 0 = hold
FlushD, FlushE, FlushM, FlushW  out  1  clear F/D, D/E, E/M, M/W register inputs to bubble
stall_cnt  out  CNT_W  saturating count of cycles with StallF=1
err_flag  out  1  sticky memory-timeout flag

Behaviour:
- State: FSM {RUN, MEM_WAIT}, wait_cnt (clog2(MEM_TIMEOUT+1) bits), stall_cnt, err_flag.
- Control outputs: combinational from state and inputs.
- reset low, asynchronous:
  - state=RUN, wait_cnt=0, stall_cnt=0, err_flag=0.
  - Combinational outputs forced while reset low: Stall*=0, EnM=1, Flush*=1, Forward*=00.
- Forwarding, zero latency:
  - ForwardAE=10 if RegWriteM & WA3M==RA1E.
  - Else ForwardAE=01 if RegWriteW & WA3W==RA1E.
  - Else ForwardAE=00.
  - Never forward when RA1E==all-ones (R15/PC).
  - ForwardBE: identical rule using RA2E.
- mem_acc = MemtoRegM | MemWriteM.
- mem_stall:
  - RUN: mem_acc & ~mem_ready.
  - MEM_WAIT: ~mem_ready & wait_cnt<MEM_TIMEOUT.
- When mem_stall=1: StallF=StallD=StallE=1, EnM=0, FlushW=1, all other flushes 0.
- Branch flush, only when mem_stall=0: PCSrcM=1 -> FlushD=FlushE=FlushM=1 for that cycle; no stalls.
  - A PCSrcM held during a memory stall (FLOPMEM is frozen) flushes exactly once, in the release cycle.
- Load-use, only when mem_stall=0 & PCSrcM=0:
  - Condition: MemtoRegE & RegWriteE & (WA3E==RA1D | WA3E==RA2D).
  - Response: StallF=StallD=1, FlushE=1, EnM=1.
- Priority: reset > mem_stall > branch flush > load-use > none.
- No hazard: all stalls/flushes 0, EnM=1.
- FSM transitions:
  - RUN: mem_acc & ~mem_ready -> MEM_WAIT, wait_cnt<=1. Otherwise stay, wait_cnt<=0.
  - MEM_WAIT, mem_ready=1: release (no stall this cycle) -> RUN, wait_cnt<=0. mem_ready wins over timeout in the same cycle.
  - MEM_WAIT, mem_ready=0 & wait_cnt<MEM_TIMEOUT: stay, wait_cnt++.
  - MEM_WAIT, mem_ready=0 & wait_cnt==MEM_TIMEOUT: forced release (no stall, pipeline advances) -> RUN, wait_cnt<=0, err_flag<=1.
- Stalled cycles per access: at most MEM_TIMEOUT.
- stall_cnt increments on every cycle with StallF=1 (memory or load-use) and saturates at all-ones.
- err_flag stays 1 until reset.
- Reset mid-wait aborts the wait immediately with no pending flush carried over.

Test Plan:
1. Forwarding:
   - RegWriteM=1, WA3M=3, RegWriteW=1, WA3W=3, RA1E=3 -> ForwardAE=10.
   - RA2E=4, WA3W=4, RegWriteM=0 -> ForwardBE=01.
   - RA1E=15 with M match -> ForwardAE=00.
2. Load-use: MemtoRegE=1, RegWriteE=1, WA3E=5, RA2D=5, mem_acc=0 -> one cycle StallF=StallD=FlushE=1, EnM=1, StallE=0; stall_cnt=1.
3. Memory wait: MemtoRegM=1, mem_ready=0 for 3 cycles then 1 -> StallF/D/E=1, EnM=0, FlushW=1 for 3 cycles; 4th cycle no stall, state RUN; stall_cnt=3, err_flag=0.
4. Branch during wait: PCSrcM=1, MemWriteM=1, mem_ready=0 for 2 cycles -> Flush D/E/M=0 during stall; FlushD=FlushE=FlushM=1 only in the release cycle, then 0.
5. Timeout: MEM_TIMEOUT=4, MemtoRegM=1, mem_ready held 0 -> exactly 4 stalled cycles, 5th cycle released with EnM=1, err_flag=1 from next edge and stays 1.
6. Reset mid-operation: drop reset during MEM_WAIT (wait_cnt=2, stall_cnt=2) -> immediately state RUN, Stall*=0, Flush*=1, stall_cnt=0, err_flag=0; after release with mem_acc=0 -> all stalls/flushes 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage core: operand forwarding, load-use
// interlock, branch flush and a wait-state FSM that freezes the pipeline on slow memory.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  RUN      | pipeline flowing; a memory access without ready enters MEM_WAIT
//  MEM_WAIT | pipeline frozen until mem_ready or the timeout forces release
module hazard_ctrl #(
    parameter int REG_W       = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] RA1D,
    input  logic [REG_W-1:0] RA2D,
    input  logic [REG_W-1:0] RA1E,
    input  logic [REG_W-1:0] RA2E,
    input  logic [REG_W-1:0] WA3E,
    input  logic [REG_W-1:0] WA3M,
    input  logic [REG_W-1:0] WA3W,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             MemtoRegM,
    input  logic             MemWriteM,
    input  logic             PCSrcM,
    input  logic             mem_ready,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             EnM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             FlushW,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             err_flag
);

    localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam logic [REG_W-1:0]  PC_REG   = '1;

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t            state, next_state;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              timeout_rel;
    logic              mem_acc;
    logic              mem_stall;
    logic              load_use;

    assign mem_acc  = MemtoRegM | MemWriteM;
    assign load_use = MemtoRegE & RegWriteE & ((WA3E == RA1D) | (WA3E == RA2D));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            wait_cnt  <= '0;
            stall_cnt <= '0;
            err_flag  <= 1'b0;
        end else begin
            state    <= next_state;
            wait_cnt <= wait_nxt;
            if (StallF && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (timeout_rel)
                err_flag <= 1'b1;
        end
    end

    always_comb begin
        next_state  = state;
        wait_nxt    = wait_cnt;
        timeout_rel = 1'b0;
        mem_stall   = 1'b0;
        case (state)
            RUN: begin
                mem_stall = mem_acc & ~mem_ready;
                if (mem_acc && !mem_ready) begin
                    next_state = MEM_WAIT;
                    wait_nxt   = WAIT_W'(1);
                end else begin
                    wait_nxt = '0;
                end
            end
            MEM_WAIT: begin
                mem_stall = ~mem_ready & (wait_cnt < WAIT_MAX);
                if (mem_ready) begin
                    next_state = RUN;
                    wait_nxt   = '0;
                end else if (wait_cnt < WAIT_MAX) begin
                    wait_nxt = wait_cnt + WAIT_W'(1);
                end else begin
                    // Give up on the access so a dead memory cannot hang the core.
                    next_state  = RUN;
                    wait_nxt    = '0;
                    timeout_rel = 1'b1;
                end
            end
            default: begin
                next_state = RUN;
                wait_nxt   = '0;
            end
        endcase
    end

    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] ra);
        logic [1:0] sel;
        sel = 2'b00;
        if (ra != PC_REG) begin
            if (RegWriteM && (WA3M == ra))
                sel = 2'b10;
            else if (RegWriteW && (WA3W == ra))
                sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        EnM       = 1'b1;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        FlushW    = 1'b0;
        if (!reset) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushM = 1'b1;
            FlushW = 1'b1;
        end else begin
            ForwardAE = fwd_sel(RA1E);
            ForwardBE = fwd_sel(RA2E);
            if (mem_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                EnM    = 1'b0;
                FlushW = 1'b1;
            end else if (PCSrcM) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
                FlushM = 1'b1;
            end else if (load_use) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expected outputs are queued as each step is driven
// and popped for comparison when the DUT response is sampled.
module tb_hazard_ctrl;

    localparam int REG_W = 4;
    localparam int CNT_W = 3;

    // {StallF, StallD, StallE, EnM, FlushD, FlushE, FlushM, FlushW}
    localparam logic [7:0] C_NONE = 8'b0001_0000;
    localparam logic [7:0] C_LU   = 8'b1101_0100;
    localparam logic [7:0] C_MEM  = 8'b1110_0001;
    localparam logic [7:0] C_BR   = 8'b0001_1110;
    localparam logic [7:0] C_RST  = 8'b0001_1111;

    logic             clk = 1'b0;
    logic             reset;
    logic [REG_W-1:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic             RegWriteE, RegWriteM, RegWriteW;
    logic             MemtoRegE, MemtoRegM, MemWriteM, PCSrcM, mem_ready;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, StallE, EnM;
    logic             FlushD, FlushE, FlushM, FlushW;
    logic [CNT_W-1:0] stall_cnt;
    logic             err_flag;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [7:0] ctrl;
        logic [3:0] fwd;
        logic [2:0] cnt;
        logic       err;
    } exp_t;

    exp_t sb[$];

    hazard_ctrl #(.REG_W(REG_W), .MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .PCSrcM(PCSrcM), .mem_ready(mem_ready),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .EnM(EnM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
        .stall_cnt(stall_cnt), .err_flag(err_flag)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ctrl_obs();
        return {StallF, StallD, StallE, EnM, FlushD, FlushE, FlushM, FlushW};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Inputs already driven at the falling edge; outputs sampled before and after the next rise.
    task automatic step(input string tag, input logic [7:0] ec, input logic [3:0] ef,
                        input logic [2:0] ecnt, input logic eerr);
        exp_t e;
        sb.push_back('{tag, ec, ef, ecnt, eerr});
        #1;
        e = sb.pop_front();
        chk({e.tag, ".ctrl"}, ctrl_obs(), e.ctrl);
        chk({e.tag, ".fwd"}, {4'b0, ForwardAE, ForwardBE}, {4'b0, e.fwd});
        @(posedge clk);
        #1;
        chk({e.tag, ".cnt"}, {5'b0, stall_cnt}, {5'b0, e.cnt});
        chk({e.tag, ".err"}, {7'b0, err_flag}, {7'b0, e.err});
        @(negedge clk);
    endtask

    task automatic rst_pulse(input string tag);
        reset = 1'b0;
        #1;
        chk({tag, ".ctrl"}, ctrl_obs(), C_RST);
        chk({tag, ".fwd"}, {4'b0, ForwardAE, ForwardBE}, 8'h00);
        chk({tag, ".cnt"}, {5'b0, stall_cnt}, 8'h00);
        chk({tag, ".err"}, {7'b0, err_flag}, 8'h00);
        @(posedge clk);
        #1;
        chk({tag, ".cnt_edge"}, {5'b0, stall_cnt}, 8'h00);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic idle_inputs();
        {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
        RA1D = 4'd1; RA2D = 4'd2; WA3E = 4'd9;
        {RegWriteE, RegWriteM, RegWriteW, MemtoRegE} = '0;
        {MemtoRegM, MemWriteM, PCSrcM} = '0;
        mem_ready = 1'b1;
    endtask

    initial begin
        idle_inputs();
        RegWriteM = 1'b1; WA3M = 4'd3; RA1E = 4'd3;
        reset = 1'b0;
        #1;
        chk("reset.ctrl", ctrl_obs(), C_RST);
        chk("reset.fwd", {4'b0, ForwardAE, ForwardBE}, 8'h00);
        chk("reset.cnt", {5'b0, stall_cnt}, 8'h00);
        chk("reset.err", {7'b0, err_flag}, 8'h00);
        @(negedge clk);
        reset = 1'b1;

        // Forwarding
        RegWriteM = 1; WA3M = 3; RegWriteW = 1; WA3W = 3; RA1E = 3; RA2E = 7;
        step("fwd_m_over_w", C_NONE, 4'b10_00, 3'd0, 1'b0);
        RegWriteM = 0; RA2E = 4; WA3W = 4;
        step("fwd_w", C_NONE, 4'b00_01, 3'd0, 1'b0);
        RegWriteM = 1; WA3M = 15; RA1E = 15; RA2E = 15; WA3W = 15;
        step("fwd_pc", C_NONE, 4'b00_00, 3'd0, 1'b0);
        WA3M = 6; WA3W = 2; RA1E = 2; RA2E = 6;
        step("fwd_both", C_NONE, 4'b01_10, 3'd0, 1'b0);
        idle_inputs();

        // Load-use
        MemtoRegE = 1; RegWriteE = 1; WA3E = 5; RA2D = 5;
        step("load_use", C_LU, 4'b0, 3'd1, 1'b0);
        idle_inputs();
        step("after_lu", C_NONE, 4'b0, 3'd1, 1'b0);

        rst_pulse("rst_a");

        // Memory wait, 3 stalled cycles then ready
        MemtoRegM = 1; mem_ready = 0;
        for (int i = 1; i <= 3; i++) step("mem_wait", C_MEM, 4'b0, 3'(i), 1'b0);
        mem_ready = 1;
        step("mem_release", C_NONE, 4'b0, 3'd3, 1'b0);
        idle_inputs();

        // Branch held during a store wait flushes only at release
        MemWriteM = 1; PCSrcM = 1; mem_ready = 0;
        step("br_wait1", C_MEM, 4'b0, 3'd4, 1'b0);
        step("br_wait2", C_MEM, 4'b0, 3'd5, 1'b0);
        mem_ready = 1;
        step("br_release", C_BR, 4'b0, 3'd5, 1'b0);
        idle_inputs();
        step("br_after", C_NONE, 4'b0, 3'd5, 1'b0);

        // Priorities: branch over load-use, memory stall over load-use
        PCSrcM = 1; MemtoRegE = 1; RegWriteE = 1; WA3E = 1;
        step("br_over_lu", C_BR, 4'b0, 3'd5, 1'b0);
        PCSrcM = 0; MemtoRegM = 1; mem_ready = 0;
        step("mem_over_lu", C_MEM, 4'b0, 3'd6, 1'b0);
        idle_inputs();
        step("mem_over_lu_rel", C_NONE, 4'b0, 3'd6, 1'b0);

        rst_pulse("rst_b");

        // mem_ready arriving on the timeout cycle wins: no error
        MemtoRegM = 1; mem_ready = 0;
        for (int i = 1; i <= 4; i++) step("ready_at_limit", C_MEM, 4'b0, 3'(i), 1'b0);
        mem_ready = 1;
        step("ready_wins", C_NONE, 4'b0, 3'd4, 1'b0);
        idle_inputs();

        rst_pulse("rst_c");

        // Timeout: 4 stalls, forced release, sticky error
        MemtoRegM = 1; mem_ready = 0;
        for (int i = 1; i <= 4; i++) step("timeout_stall", C_MEM, 4'b0, 3'(i), 1'b0);
        step("timeout_release", C_NONE, 4'b0, 3'd4, 1'b1);
        idle_inputs();
        step("err_sticky", C_NONE, 4'b0, 3'd4, 1'b1);

        // Reset in the middle of a wait with a branch pending
        MemtoRegM = 1; mem_ready = 0; PCSrcM = 1;
        step("mid_wait1", C_MEM, 4'b0, 3'd5, 1'b1);
        step("mid_wait2", C_MEM, 4'b0, 3'd6, 1'b1);
        rst_pulse("rst_mid");
        idle_inputs();
        step("post_rst", C_NONE, 4'b0, 3'd0, 1'b0);

        // Full timeout again after the aborted wait
        MemtoRegM = 1; mem_ready = 0;
        for (int i = 1; i <= 4; i++) step("timeout2_stall", C_MEM, 4'b0, 3'(i), 1'b0);
        step("timeout2_release", C_NONE, 4'b0, 3'd4, 1'b1);
        idle_inputs();

        // Counter saturation
        MemtoRegE = 1; RegWriteE = 1; WA3E = 1; RA1D = 1;
        step("sat5", C_LU, 4'b0, 3'd5, 1'b1);
        step("sat6", C_LU, 4'b0, 3'd6, 1'b1);
        step("sat7", C_LU, 4'b0, 3'd7, 1'b1);
        step("sat_hold1", C_LU, 4'b0, 3'd7, 1'b1);
        step("sat_hold2", C_LU, 4'b0, 3'd7, 1'b1);
        idle_inputs();

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d entries expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
